// File: rtl/ibus_arb.sv
`default_nettype none
// ==========================================================================
// ibus_arb : shares one req/gnt/rvalid memory port between IFU fetch and LSU.
// Optional IBUS_ARB_RR_EN: round-robin tie-break instead of fixed LSU priority.
// Revision: 1.0
// ==========================================================================
module ibus_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_rvalid_o,
  output logic            if_stall_req_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [DW/8-1:0] ls_be_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            ls_rvalid_o,
  output logic            ls_stall_req_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            bus_err_o
);

  localparam logic       OWNER_LS   = 1'b0;
  localparam logic       OWNER_IF   = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_d, mem_we_d;
  logic [DW/8-1:0]   mem_be_d;
  logic [AW-1:0]     mem_addr_d;
  logic [DW-1:0]     mem_wdata_d;
  logic              resp_valid;
  logic              resp_err;
  logic              pick_if;
  logic [DW-1:0]     resp_data;

`ifdef IBUS_ARB_RR_EN
  logic last_owner_q;

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    pick_if = if_req_i;
    if (if_req_i && ls_req_i) begin
      pick_if = (last_owner_q == OWNER_LS);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_owner_q <= OWNER_LS;
    end else if (state_q == IDLE && (if_req_i || ls_req_i)) begin
      last_owner_q <= pick_if;
    end
  end
`else
  assign pick_if = if_req_i & ~ls_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_LS;
      drop_q      <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_be_o    <= mem_be_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_be_d    = mem_be_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d   = REQ;
          owner_d   = pick_if;
          drop_d    = 1'b0;
          mem_req_d = 1'b1;
          if (pick_if) begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end else begin
            mem_we_d    = ls_we_i;
            mem_be_d    = ls_be_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
          end
        end
      end

      REQ: begin
        if (flush_i && owner_q == OWNER_IF) begin
          drop_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
        end
      end

      WAIT: begin
        if (flush_i && owner_q == OWNER_IF) begin
          drop_d = 1'b1;
        end
        // A real response beats a timeout landing in the same cycle.
        if (mem_rvalid_i) begin
          resp_valid = 1'b1;
          state_d    = IDLE;
          drop_d     = 1'b0;
          cnt_d      = 8'd0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_d    = IDLE;
          drop_d     = 1'b0;
          cnt_d      = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign resp_data = resp_err ? '0 : mem_rdata_i;

  // A flush arriving with the response itself also makes the fetch stale.
  assign if_rvalid_o = resp_valid & (owner_q == OWNER_IF) & ~drop_q & ~flush_i;
  assign ls_rvalid_o = resp_valid & (owner_q == OWNER_LS);
  assign if_rdata_o  = resp_data;
  assign ls_rdata_o  = resp_data;
  assign bus_err_o   = resp_err;

  assign if_stall_req_o = if_req_i & ~if_rvalid_o;
  assign ls_stall_req_o = ls_req_i & ~ls_rvalid_o;

endmodule
`default_nettype wire

// File: tb/tb_ibus_arb.sv
`default_nettype none
// tb_ibus_arb : randomized requester/memory agents checked against a transaction-level model.
module tb_ibus_arb;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_rvalid_o;
  logic          if_stall_req_o;
  logic          ls_req_i = 1'b0;
  logic          ls_we_i = 1'b0;
  logic [BW-1:0] ls_be_i = '0;
  logic [AW-1:0] ls_addr_i = '0;
  logic [DW-1:0] ls_wdata_i = '0;
  logic [DW-1:0] ls_rdata_o;
  logic          ls_rvalid_o;
  logic          ls_stall_req_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          bus_err_o;

  always #5 clk = ~clk;

  ibus_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .if_rvalid_o    (if_rvalid_o),
    .if_stall_req_o (if_stall_req_o),
    .ls_req_i       (ls_req_i),
    .ls_we_i        (ls_we_i),
    .ls_be_i        (ls_be_i),
    .ls_addr_i      (ls_addr_i),
    .ls_wdata_i     (ls_wdata_i),
    .ls_rdata_o     (ls_rdata_o),
    .ls_rvalid_o    (ls_rvalid_o),
    .ls_stall_req_o (ls_stall_req_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .bus_err_o      (bus_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester state: each side holds its request until it is answered.
  bit            if_pend, ls_pend;
  logic [AW-1:0] if_a, ls_a;
  bit            ls_w;
  logic [BW-1:0] ls_b;
  logic [DW-1:0] ls_d;

  // The one transaction the shared port may carry at a time.
  bit            act, granted, dropped, own_if, last_if;
  logic [AW-1:0] t_addr;
  bit            t_we;
  logic [BW-1:0] t_be;
  logic [DW-1:0] t_wd;
  int            k, delay;

  int gnt_pct, new_pct, flush_pct, never_pct;
  bit fixed_timing;

  task automatic model_reset();
    if_pend = 0; ls_pend = 0;
    act = 0; granted = 0; dropped = 0; own_if = 0; last_if = 0;
    k = 0; delay = 0;
  endtask

  task automatic step();
    bit            fl, g, rv, to, done, dn, exp_if, exp_ls, win_if;
    logic [DW-1:0] rd;
    @(negedge clk);
    if (!if_pend && new_pct > 0 && $urandom_range(99) < new_pct) begin
      if_pend = 1;
      if_a    = $urandom() & 32'hFFFF_FFFC;
    end
    if (!ls_pend && new_pct > 0 && $urandom_range(99) < new_pct) begin
      ls_pend = 1;
      ls_a    = $urandom() & 32'hFFFF_FFFC;
      ls_w    = 1'($urandom_range(1));
      ls_b    = 4'($urandom_range(15));
      ls_d    = $urandom();
    end
    fl = (flush_pct > 0) && ($urandom_range(99) < flush_pct);
    if (fl && if_pend) if_a = $urandom() & 32'hFFFF_FFFC;
    g  = act && !granted && (fixed_timing || $urandom_range(99) < gnt_pct);
    rv = act && granted && (k == delay);
    if (!act && !fixed_timing && $urandom_range(3) == 0) rv = 1;
    to   = act && granted && !rv && (k == TIMEOUT + 1);
    done = act && granted && (rv || to);
    rd   = $urandom();

    if_req_i = if_pend; if_addr_i = if_a;
    ls_req_i = ls_pend; ls_we_i = ls_w; ls_be_i = ls_b; ls_addr_i = ls_a; ls_wdata_i = ls_d;
    flush_i = fl; mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    #1;

    dn     = dropped || (fl && act && own_if);
    exp_if = done && own_if && !dn;
    exp_ls = done && !own_if;
    check("mem_req", mem_req_o, act && !granted);
    if (act && !granted) begin
      check("mem_addr", mem_addr_o, t_addr);
      check("mem_we", mem_we_o, t_we);
      check("mem_be", mem_be_o, t_be);
      if (!own_if) check("mem_wdata", mem_wdata_o, t_wd);
    end
    check("if_rvalid", if_rvalid_o, exp_if);
    check("ls_rvalid", ls_rvalid_o, exp_ls);
    check("bus_err", bus_err_o, to);
    if (exp_if) check("if_rdata", if_rdata_o, to ? '0 : rd);
    if (exp_ls) check("ls_rdata", ls_rdata_o, to ? '0 : rd);
    check("if_stall", if_stall_req_o, if_pend && !exp_if);
    check("ls_stall", ls_stall_req_o, ls_pend && !exp_ls);

    if (act) begin
      dropped = dn;
      if (!granted) begin
        if (g) begin
          granted = 1;
          k       = 1;
          if (fixed_timing) delay = 1;
          else if ($urandom_range(99) < never_pct) delay = 1000;
          else delay = $urandom_range(TIMEOUT + 1, 1);
        end
      end else if (done) begin
        act = 0;
        if (own_if) begin
          if (!dn) if_pend = 0;
        end else begin
          ls_pend = 0;
        end
      end else begin
        k++;
      end
    end else if (if_pend || ls_pend) begin
`ifdef IBUS_ARB_RR_EN
      win_if = (if_pend && ls_pend) ? !last_if : if_pend;
`else
      win_if = !ls_pend;
`endif
      own_if  = win_if;
      last_if = win_if;
      act = 1; granted = 0; dropped = 0;
      if (win_if) begin
        t_addr = if_a; t_we = 0; t_be = '1; t_wd = '0;
      end else begin
        t_addr = ls_a; t_we = ls_w; t_be = ls_b; t_wd = ls_d;
      end
    end
  endtask

  // Reset cycle, then a late memory response that must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_i = 1; if_req_i = 0; ls_req_i = 0; flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    @(negedge clk);
    rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_be", mem_be_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_bus_err", bus_err_o, 0);
    check("rst_if_rvalid", if_rvalid_o, 0);
    check("rst_ls_rvalid", ls_rvalid_o, 0);
    model_reset();
  endtask

  initial begin
    model_reset();
    fixed_timing = 1; gnt_pct = 100; new_pct = 0; flush_pct = 0; never_pct = 0;
    do_reset();

    // Single fetch at minimum latency.
    if_pend = 1; if_a = 32'h0000_0100;
    repeat (4) step();

    // Collision: LSU write against a fetch.
    if_pend = 1; if_a = 32'h0000_0104;
    ls_pend = 1; ls_w = 1; ls_a = 32'h0000_2000; ls_d = 32'hDEAD_BEEF; ls_b = 4'hF;
    repeat (8) step();

    // Random traffic with backpressure, flushes and timeouts.
    fixed_timing = 0; gnt_pct = 40; new_pct = 30; flush_pct = 8; never_pct = 10;
    repeat (3000) step();

    // Reset while a transaction is waiting for its response.
    for (int i = 0; i < 200 && !(act && granted); i++) step();
    check("reach_wait", act && granted, 1);
    do_reset();
    repeat (300) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibus_arb.md
Name: ibus_arb

Overview:
- Arbitrates the single shared instruction/data memory port between the IFU fetch path and the LSU.
- Sits between ifu/lsu and the memory.
- Sequences each access with a req/gnt/rvalid handshake.
- Raises per-requester stall requests to the pipeline controller until that requester's data returns.
- Drops fetch responses that a pipeline flush has made stale.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max cycles in WAIT before a forced error completion (range 1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush from CTRL; invalidates the in-flight fetch
if_req_i  in  1  fetch request (ifu ce_o)
if_addr_i  in  AW  fetch address (ifu pc_o)
if_rdata_o  out  DW  fetched instruction
if_rvalid_o  out  1  fetch data valid, 1-cycle pulse
if_stall_req_o  out  1  stall request for IF stage
ls_req_i  in  1  LSU request
ls_we_i  in  1  1=write
ls_be_i  in  DW/8  byte enables
ls_addr_i  in  AW  LSU address
ls_wdata_i  in  DW  LSU write data
ls_rdata_o  out  DW  LSU read data
ls_rvalid_o  out  1  LSU completion pulse (reads and writes)
ls_stall_req_o  out  1  stall request for MEM stage
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  DW/8  memory byte enables
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_gnt_i  in  1  memory accepted the request
mem_rvalid_i  in  1  memory response valid (writes also return rvalid)
mem_rdata_i  in  DW  memory read data
bus_err_o  out  1  1-cycle pulse on timeout

Behaviour:
- Reset, synchronous on rst_i:
  - FSM goes to IDLE; owner=LS; drop=0; counter=0.
  - mem_req_o, mem_we_o=0; mem_be_o, mem_addr_o, mem_wdata_o=0.
  - bus_err_o=0; both rvalid outputs=0.
  - Reset mid-transaction abandons it. An mem_rvalid_i arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when if_req_i or ls_req_i is high (registered decision).
  - On this transition, latch owner and the winner's we/be/addr/wdata into the mem_* registers, and set mem_req_o=1.
  - IF fetches always drive we=0 and be=all ones.
  - REQ: hold mem_req_o and all mem_* fields stable until mem_gnt_i. On gnt, go to WAIT, clear mem_req_o, clear counter.
  - WAIT: on mem_rvalid_i, pass mem_rdata_i combinationally to the owner's rdata and pulse the owner's rvalid the same cycle, then go to IDLE.
  - rvalid is never accepted in the gnt cycle; it arrives at least 1 cycle after gnt.
- Minimum latency:
  - Request seen in IDLE at cycle N: mem_req_o high at N+1; gnt at N+1; rvalid earliest at N+2.
  - The next IDLE decision is at N+3.
- Arbitration: when both request in IDLE, LSU wins (fixed priority; the LSU serves the older instruction).
- Stall outputs (combinational):
  - if_stall_req_o = if_req_i & ~if_rvalid_o.
  - ls_stall_req_o = ls_req_i & ~ls_rvalid_o.
- Requester contract: hold req/addr/data until its rvalid. The arbiter's latch makes later address changes harmless.
- Flush:
  - flush_i while owner=IF in REQ or WAIT sets drop=1.
  - The memory transaction still completes; gnt is not withdrawn.
  - The matching rvalid is consumed without asserting if_rvalid_o, and drop clears.
  - flush_i in IDLE has no effect.
  - flush_i with owner=LS has no effect.
  - flush_i in the same cycle as the IF rvalid suppresses that pulse.
- Timeout:
  - In WAIT, counter increments each cycle without rvalid.
  - When the counter reaches TIMEOUT: go to IDLE, pulse bus_err_o, and pulse the owner's rvalid with rdata=0.
  - If drop=1, the rvalid pulse is suppressed but bus_err_o still pulses.
  - Counter width is 8 bits; saturation is not reached because the counter is cleared on exit.
- Simultaneous events:
  - rvalid and timeout in the same cycle: rvalid wins, no error.
  - rst_i overrides everything.

Optional Feature:
- Macro: IBUS_ARB_RR_EN.
- Defined: round-robin arbitration. When both request in IDLE, the requester that did not own the previous transaction wins. last_owner resets to LS, so IF wins the first tie.
- Undefined: fixed LSU priority as above. No last_owner register.

Test Plan:
- Single fetch:
  - Stimulus: if_req_i=1, if_addr_i=0x0000_0100; gnt at first mem_req_o cycle; rvalid 1 cycle later with rdata=0x0000_0013.
  - Response: mem_addr_o=0x100, mem_we_o=0; if_stall_req_o high for 2 cycles; if_rvalid_o pulses with 0x13 at N+2.
- Collision:
  - Stimulus: if_req_i and ls_req_i (write, addr 0x2000, wdata 0xDEADBEEF, be 0xF) both rise at cycle N.
  - Response: LSU granted first with mem_we_o=1 and mem_wdata_o=0xDEADBEEF; IF served next.
  - With IBUS_ARB_RR_EN: IF is served first.
- Gnt backpressure:
  - Stimulus: hold mem_gnt_i=0 for 5 cycles.
  - Response: mem_req_o and mem_addr_o stay stable for all 5 cycles; no rvalid pulses.
- Flush drop:
  - Stimulus: IF fetch of 0x104 in WAIT; flush_i pulses; rvalid returns 0x00A00093.
  - Response: if_rvalid_o stays 0; the next fetch at 0x200 completes normally.
- Timeout:
  - Stimulus: TIMEOUT=4; LSU read granted, rvalid never arrives.
  - Response: after 4 WAIT cycles, bus_err_o and ls_rvalid_o pulse with ls_rdata_o=0; FSM returns to IDLE.
- Reset mid-operation:
  - Stimulus: rst_i in WAIT, then a late mem_rvalid_i.
  - Response: all outputs 0 the next cycle; the late rvalid is ignored; no requester rvalid.
